// File: rtl/bcd_display_scanner.sv
// 6-digit multiplexed 7-segment scanner for hh:mm:ss BCD time with per-frame snapshot and slot blanking.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses the hh_tens digit when it is zero.
module bcd_display_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hh_tens,
  input  logic [3:0] hh_ones,
  input  logic [3:0] mm_tens,
  input  logic [3:0] mm_ones,
  input  logic [3:0] ss_tens,
  input  logic [3:0] ss_ones,
  input  logic [5:0] dp_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       frame_start
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [5:0] AN_OFF  = {6{AN_ACTIVE_LOW}};

  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [3:0]    digit_in [6];
  logic [3:0]    snap_reg [6];
  logic [5:0]    dp_snap_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;
  logic [5:0]    an_reg;
  logic          frame_start_reg;

  logic          frame_edge;
  logic          cnt_wrap;
  logic [3:0]    cur_digit;
  logic          blank_slot;
  logic          drive;
  logic [6:0]    seg_next;
  logic [5:0]    an_next;
  logic          dp_next;

  assign digit_in[0] = ss_ones;
  assign digit_in[1] = ss_tens;
  assign digit_in[2] = mm_ones;
  assign digit_in[3] = mm_tens;
  assign digit_in[4] = hh_ones;
  assign digit_in[5] = hh_tens;

  assign frame_edge = (cnt_reg == '0) && (idx_reg == 3'd0);
  assign cnt_wrap   = (cnt_reg == CW'(SCAN_DIV - 1));
  assign cur_digit  = snap_reg[idx_reg];

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_slot = (idx_reg == 3'd5) && (cur_digit == 4'd0);
`else
  assign blank_slot = 1'b0;
`endif

  assign drive = (cnt_reg >= CW'(BLANK_CYCLES)) && !blank_slot;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    seg_next = 7'b0;
    an_next  = 6'b0;
    dp_next  = 1'b0;
    if (drive) begin
      seg_next = decode(cur_digit);
      an_next  = 6'(6'b1 << idx_reg);
      dp_next  = dp_snap_reg[idx_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      idx_reg <= 3'd0;
    end else if (cnt_wrap) begin
      cnt_reg <= '0;
      idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Whole-frame snapshot prevents a displayed time from mixing two input values.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_snap
      always_ff @(posedge clk) begin
        if (reset)
          snap_reg[gi] <= 4'd0;
        else if (frame_edge)
          snap_reg[gi] <= digit_in[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      dp_snap_reg <= 6'b0;
    else if (frame_edge)
      dp_snap_reg <= dp_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_reg         <= SEG_OFF;
      dp_reg          <= DP_OFF;
      an_reg          <= AN_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      seg_reg         <= SEG_ACTIVE_LOW ? ~seg_next : seg_next;
      dp_reg          <= SEG_ACTIVE_LOW ? ~dp_next : dp_next;
      an_reg          <= AN_ACTIVE_LOW ? ~an_next : an_next;
      frame_start_reg <= frame_edge;
    end
  end

  assign seg         = seg_reg;
  assign dp          = dp_reg;
  assign an          = an_reg;
  assign frame_start = frame_start_reg;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner; expected outputs derive from the cycle count since reset release.
module tb_bcd_display_scanner;
  localparam int SCAN_DIV = 4;
  localparam int BLANK    = 1;
  localparam int FRAME    = 6 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din [6];
  logic [5:0] dp_mask = 6'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_start;

  logic [6:0] dec_tbl [16];
  logic [3:0] snap [6];
  logic [5:0] snap_dp;
  int         k = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .hh_tens(din[5]), .hh_ones(din[4]), .mm_tens(din[3]), .mm_ones(din[2]),
    .ss_tens(din[1]), .ss_ones(din[0]), .dp_mask(dp_mask),
    .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got=%0h expected=%0h", tag, k, got, exp);
    end
  endtask

  // One clock edge: predict the registered outputs, let the edge happen, compare.
  task automatic step();
    int p, id, c;
    logic [6:0] e_seg;
    logic [5:0] e_an;
    logic       e_dp, e_fs;
    e_seg = 7'b0; e_an = 6'b0; e_dp = 1'b0; e_fs = 1'b0;
    if (!reset) begin
      p  = k % FRAME;
      id = p / SCAN_DIV;
      c  = p % SCAN_DIV;
      e_fs = (p == 0);
      if (c >= BLANK) begin
        e_an  = 6'(1 << id);
        e_seg = dec_tbl[snap[id]];
        e_dp  = snap_dp[id];
`ifdef LEADING_ZERO_BLANK_EN
        if (id == 5 && snap[5] == 4'd0) begin
          e_an = 6'b0; e_seg = 7'b0; e_dp = 1'b0;
        end
`endif
      end
      if (p == 0) begin
        for (int i = 0; i < 6; i++) snap[i] = din[i];
        snap_dp = dp_mask;
      end
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("an", 32'(an), 32'(e_an));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    if (reset) k = 0;
    else k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    dec_tbl[0] = 7'b0111111; dec_tbl[1] = 7'b0000110; dec_tbl[2] = 7'b1011011;
    dec_tbl[3] = 7'b1001111; dec_tbl[4] = 7'b1100110; dec_tbl[5] = 7'b1101101;
    dec_tbl[6] = 7'b1111101; dec_tbl[7] = 7'b0000111; dec_tbl[8] = 7'b1111111;
    dec_tbl[9] = 7'b1101111;
    for (int i = 10; i < 16; i++) dec_tbl[i] = 7'b1000000;
    for (int i = 0; i < 6; i++) snap[i] = 4'd0;
    snap_dp = 6'b0;

    din[5] = 4'd1; din[4] = 4'd2; din[3] = 4'd3; din[2] = 4'd4; din[1] = 4'd5; din[0] = 4'd6;
    @(negedge clk);

    $display("txn: reset held 3 cycles, time 12:34:56");
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(FRAME + 10);

    $display("txn: ss_ones -> 7 mid slot 2");
    din[0] = 4'd7;
    run(FRAME + 14);

    $display("txn: ss_ones=C, dp_mask=000100");
    din[0] = 4'hC;
    dp_mask = 6'b000100;
    run(2 * FRAME);

    $display("txn: reset at slot 3 cnt 2");
    while (k % FRAME != 3 * SCAN_DIV + 2) step();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(FRAME + 6);

    $display("txn: hh_tens=0 frame");
    din[5] = 4'd0;
    dp_mask = 6'b100001;
    run(2 * FRAME);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 6; i++) din[i] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) din[5] = 4'd0;
      dp_mask = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        run($urandom_range(1, 3));
        reset = 1'b0;
      end
      $display("txn: random %0d digits %0h%0h:%0h%0h:%0h%0h dp=%b", t,
               din[5], din[4], din[3], din[2], din[1], din[0], dp_mask);
      run($urandom_range(1, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
